bitwise_shift_arbiter: RTL and testbench
========================================

# bitwise_shift_arbiter

Round-robin arbiter that shares a single logical right shifter (operand width N, shift amount width O) among R independent requesters. Each requester uses a valid/ready handshake. Granted operations are shifted and captured in a one-entry output register tagged with the requester index. The block sits between several datapath clients in BasicCombinationalLogic-based designs and one shift resource, so a single shifter instance can serve multiple users.

## Interface
- N, 8: operand/result width in bits; N >= 2.
- O, $clog2(N): shift-amount width.
- R, 4: number of requesters; R >= 2.
- RW, $clog2(R): width of the requester-ID tag.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  R  bit r: requester r presents an operation.
- req_ready  output  R  bit r: requester r's operation is accepted this cycle; one-hot or zero.
- req_a  input  R*N  operand A; requester r at [r*N +: N].
- req_b  input  R*O  shift amount; requester r at [r*O +: O].
- rsp_valid  output  1  rsp_c and rsp_id hold a result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_c  output  N  result, a >> b.
- rsp_id  output  RW  index of the requester that produced rsp_c.

## Operation
- Output register states:
  - EMPTY: rsp_valid = 0.
  - FULL: rsp_valid = 1.
- Slot is free when (!rsp_valid || rsp_ready).
- Grant:
  - Combinational, from req_valid and the round-robin pointer ptr.
  - Winner is the first r with req_valid[r] = 1, searching ptr, ptr+1, … modulo R.
  - req_ready[winner] = 1 only when the slot is free. All other req_ready bits are 0.
- Accept occurs when req_valid[r] && req_ready[r]. On accept:
  - rsp_c <= req_a[r] >> req_b[r], logical, zero-filled.
  - rsp_id <= r.
  - rsp_valid <= 1.
  - ptr <= (r+1) mod R.
- Drain without accept: when rsp_valid && rsp_ready and nothing is accepted, rsp_valid <= 0. rsp_c and rsp_id hold their last values.
- Drain and accept in the same cycle: the new result replaces the old one and rsp_valid stays 1. Throughput is one operation per cycle.
- FULL && !rsp_ready: all req_ready = 0 and rsp_c, rsp_id, rsp_valid hold stable (backpressure).
- ptr does not move without an accept.
- Requester rule: once asserted, req_valid[r] and its operands stay stable until accepted. The bench checks this; RTL does not depend on it.
- Shift arithmetic:
  - b ranges 0..2^O-1.
  - If b >= N (possible when N is not a power of two), the result is 0.
  - b = 0 passes a through unchanged.

## Timing
- Latency: an operation accepted on edge k appears with rsp_valid = 1 after edge k, visible in cycle k+1.
- req_ready is combinational from req_valid, rsp_valid, rsp_ready and ptr. It has no combinational path from req_a or req_b.
- Reset values: rsp_valid = 0, rsp_c = 0, rsp_id = 0, ptr = 0. req_ready is therefore 0 for every requester except possibly the one selected combinationally.
- Asserting rst_n low mid-operation discards a held result immediately (asynchronous). The first accept after reset release goes to the lowest valid index.

## Configuration
- BITWISE_SHIFT_ARB_ROUND_ROBIN_EN:
  - Defined: round-robin grant as specified in Operation.
  - Undefined: fixed priority, where the lowest valid index always wins. ptr is not implemented and rsp_id semantics are unchanged.
  - Handshake, latency and shift behaviour are identical in both builds.

## Test plan
- Reset with all req_valid = 0:
  - Required: rsp_valid = 0, rsp_c = 0, rsp_id = 0, req_ready = 0.
- Single request, N=8, requester 2 sends a=8'hB4, b=3, rsp_ready=1:
  - Required: req_ready = 4'b0100 in the same cycle.
  - Next cycle: rsp_c = 8'h16, rsp_id = 2, rsp_valid = 1.
- All four requesters valid continuously, rsp_ready = 1, round-robin build:
  - Required: grants in order 0,1,2,3,0, one per cycle, with no idle cycle.
  - Fixed-priority build: requester 0 granted every cycle.
- Backpressure: result held with rsp_ready = 0 for 5 cycles while requester 1 is valid:
  - Required: req_ready = 0 and rsp_c/rsp_id stable throughout.
  - When rsp_ready rises: requester 1 is accepted in that same cycle, and its result appears in the next cycle.
- Boundary shifts, a = 8'hFF:
  - b=0 -> 8'hFF.
  - b=7 -> 8'h01.
  - Build with N=6, O=3, a=6'h3F, b=6 -> 0; b=7 -> 0.
- Reset mid-operation: assert rst_n low while rsp_valid = 1 and ptr = 3:
  - Required: rsp_valid = 0 immediately.
  - After release with requesters 1 and 3 valid: requester 1 is granted first (ptr = 0).

Source files
------------

// File: rtl/bitwise_shift_arbiter_if.sv
// Purpose: requester/response bundle for the shared right-shifter arbiter.
// Latency: none; this file holds signals only.
// Backpressure: req_ready per requester and rsp_ready from downstream.
// Ports:
//   req_valid/req_ready  R-bit request handshake, one bit per requester.
//   req_a                R*N operand bus, requester r at [r*N +: N].
//   req_b                R*O shift-amount bus, requester r at [r*O +: O].
//   rsp_valid/rsp_ready  result handshake.
//   rsp_c/rsp_id         result and the index of the requester that produced it.
// master = client/bench side, slave = arbiter side.
interface bitwise_shift_arbiter_if #(
  parameter int N  = 8,
  parameter int O  = $clog2(N),
  parameter int R  = 4,
  parameter int RW = $clog2(R)
);
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*O-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_c;
  logic [RW-1:0]  rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_id
  );
endinterface

// File: rtl/bitwise_shift_arbiter.sv
// Purpose: shares one logical right shifter (a >> b) among R requesters.
// Latency: result registered; accept on edge k is visible in cycle k+1.
// Backpressure: req_ready all zero while a result is held and rsp_ready is low.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset.
//   bus (slave)  request handshake + operands in, tagged result out.
// Config macro BITWISE_SHIFT_ARB_ROUND_ROBIN_EN: defined selects round-robin
// grant starting at a rotating pointer; undefined selects fixed priority
// (lowest valid index wins) and the pointer is not built.
module bitwise_shift_arbiter #(
  parameter int N  = 8,
  parameter int O  = $clog2(N),
  parameter int R  = 4,
  parameter int RW = $clog2(R)
) (
  input logic                  clk,
  input logic                  rst_n,
  bitwise_shift_arbiter_if.slave bus
);

  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_c_q, rsp_c_d;
  logic [RW-1:0] rsp_id_q, rsp_id_d;

  logic          any_valid;
  logic [RW-1:0] win_id;
  logic          slot_free;
  logic          accept;
  logic [R-1:0]  ready;
  logic [N-1:0]  win_a;
  logic [O-1:0]  win_b;

`ifdef BITWISE_SHIFT_ARB_ROUND_ROBIN_EN
  logic [RW-1:0] ptr_q, ptr_d;

  // Scan from the far end of the rotation back to ptr so the last write is
  // the first valid requester at or after ptr.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    win_id    = '0;
    for (int i = R - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % R;
      if (bus.req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = RW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (win_id == RW'(R - 1)) ? '0 : win_id + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Downward scan: the lowest valid index is written last and wins.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        any_valid = 1'b1;
        win_id    = RW'(i);
      end
    end
  end
`endif

  // Grant depends only on valids, slot state and pointer; operands feed the
  // shifter only, keeping req_ready free of any path from req_a/req_b.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    accept    = any_valid && slot_free;
    ready     = '0;
    if (accept) begin
      ready[win_id] = 1'b1;
    end
    win_a = bus.req_a[win_id*N +: N];
    win_b = bus.req_b[win_id*O +: O];
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_c_d     = rsp_c_q;
    rsp_id_d    = rsp_id_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      // Shift amounts >= N clear the result naturally with a logical shift.
      rsp_c_d     = win_a >> win_b;
      rsp_id_d    = win_id;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_c_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_c_q     <= rsp_c_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_bitwise_shift_arbiter.sv
// Purpose: directed, table-driven check of the shift arbiter (N=8/R=4 and N=6/R=2).
// Latency: expects results one cycle after the accepting edge.
// Backpressure: exercises held results with rsp_ready low.
module tb_bitwise_shift_arbiter;

`ifdef BITWISE_SHIFT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;

  bitwise_shift_arbiter_if #(.N(8), .O(3), .R(4), .RW(2)) bus8 ();
  bitwise_shift_arbiter_if #(.N(6), .O(3), .R(2), .RW(1)) bus6 ();

  bitwise_shift_arbiter #(.N(8), .O(3), .R(4), .RW(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  bitwise_shift_arbiter #(.N(6), .O(3), .R(2), .RW(1)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [2:0] b;
    logic [7:0] exp_c;
  } vec8_t;

  typedef struct {
    int         id;
    logic [5:0] a;
    logic [2:0] b;
    logic [5:0] exp_c;
  } vec6_t;

  vec8_t v8[7];
  vec6_t v6[4];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    v8[0] = '{2, 8'hB4, 3'd3, 8'h16};
    v8[1] = '{0, 8'hFF, 3'd0, 8'hFF};
    v8[2] = '{1, 8'hFF, 3'd7, 8'h01};
    v8[3] = '{3, 8'h80, 3'd1, 8'h40};
    v8[4] = '{0, 8'hA5, 3'd4, 8'h0A};
    v8[5] = '{3, 8'h01, 3'd0, 8'h01};
    v8[6] = '{1, 8'hF0, 3'd5, 8'h07};

    v6[0] = '{0, 6'h3F, 3'd6, 6'h00};
    v6[1] = '{1, 6'h3F, 3'd7, 6'h00};
    v6[2] = '{0, 6'h3F, 3'd2, 6'h0F};
    v6[3] = '{1, 6'h3F, 3'd0, 6'h3F};

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus8.req_valid = '0; bus8.req_a = '0; bus8.req_b = '0; bus8.rsp_ready = 1'b0;
    bus6.req_valid = '0; bus6.req_a = '0; bus6.req_b = '0; bus6.rsp_ready = 1'b0;

    // Reset state with nothing requesting.
    #22;
    chk("reset_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
    chk("reset_rsp_c",     32'(bus8.rsp_c),     32'd0);
    chk("reset_rsp_id",    32'(bus8.rsp_id),    32'd0);
    chk("reset_req_ready", 32'(bus8.req_ready), 32'd0);
    chk("reset6_rsp_valid", 32'(bus6.rsp_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Single-request vectors, one at a time, rsp_ready held high.
    bus8.rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus8.req_valid = '0;
      bus8.req_valid[v8[k].id] = 1'b1;
      bus8.req_a[v8[k].id*8 +: 8] = v8[k].a;
      bus8.req_b[v8[k].id*3 +: 3] = v8[k].b;
      #1;
      chk($sformatf("vec%0d_req_ready", k), 32'(bus8.req_ready), 32'(1) << v8[k].id);
      step();
      chk($sformatf("vec%0d_rsp_valid", k), 32'(bus8.rsp_valid), 32'd1);
      chk($sformatf("vec%0d_rsp_c", k),     32'(bus8.rsp_c),     32'(v8[k].exp_c));
      chk($sformatf("vec%0d_rsp_id", k),    32'(bus8.rsp_id),    32'(v8[k].id));
      bus8.req_valid = '0;
    end
    #1;
    step();
    chk("drain_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
    chk("drain_rsp_c_hold", 32'(bus8.rsp_c), 32'h07);

    // N=6 build: shift amounts at and beyond the width clear the result.
    bus6.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus6.req_valid = '0;
      bus6.req_valid[v6[k].id] = 1'b1;
      bus6.req_a[v6[k].id*6 +: 6] = v6[k].a;
      bus6.req_b[v6[k].id*3 +: 3] = v6[k].b;
      #1;
      chk($sformatf("n6vec%0d_req_ready", k), 32'(bus6.req_ready), 32'(1) << v6[k].id);
      step();
      chk($sformatf("n6vec%0d_rsp_c", k),  32'(bus6.rsp_c),  32'(v6[k].exp_c));
      chk($sformatf("n6vec%0d_rsp_id", k), 32'(bus6.rsp_id), 32'(v6[k].id));
      bus6.req_valid = '0;
    end

    // Fresh reset so the pointer starts at 0, then all four requesting.
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    bus8.req_a = {8'h44, 8'h33, 8'h22, 8'h11};
    bus8.req_b = '0;
    bus8.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int exp_id;
      exp_id = RR ? (k % 4) : 0;
      #1;
      chk($sformatf("rr%0d_req_ready", k), 32'(bus8.req_ready), 32'(1) << exp_id);
      step();
      chk($sformatf("rr%0d_rsp_valid", k), 32'(bus8.rsp_valid), 32'd1);
      chk($sformatf("rr%0d_rsp_id", k),    32'(bus8.rsp_id),    32'(exp_id));
      chk($sformatf("rr%0d_rsp_c", k),     32'(bus8.rsp_c),     32'(8'h11 * (exp_id + 1)));
    end

    // Backpressure: last result (requester 0, 0x11) held while requester 1 waits.
    bus8.req_valid = 4'b0010;
    bus8.req_a[8 +: 8] = 8'hC3;
    bus8.req_b[3 +: 3] = 3'd2;
    bus8.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_req_ready", k), 32'(bus8.req_ready), 32'd0);
      step();
      chk($sformatf("bp%0d_rsp_valid", k), 32'(bus8.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_c", k),     32'(bus8.rsp_c),     32'h11);
      chk($sformatf("bp%0d_rsp_id", k),    32'(bus8.rsp_id),    32'd0);
    end
    bus8.rsp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", 32'(bus8.req_ready), 32'b0010);
    step();
    chk("bp_release_rsp_c",  32'(bus8.rsp_c),  32'h30);
    chk("bp_release_rsp_id", 32'(bus8.rsp_id), 32'd1);

    // Load requester 2 so the pointer sits at 3, then hold and reset.
    bus8.req_valid = 4'b0100;
    bus8.req_a[16 +: 8] = 8'h5A;
    bus8.req_b[6 +: 3] = 3'd1;
    step();
    chk("pre_rst_rsp_id", 32'(bus8.rsp_id), 32'd2);
    chk("pre_rst_rsp_c",  32'(bus8.rsp_c),  32'h2D);
    bus8.req_valid = '0;
    bus8.rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
    chk("midrst_rsp_c",     32'(bus8.rsp_c),     32'd0);
    bus8.req_valid = 4'b1010;
    bus8.rsp_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    #1;
    chk("postrst_req_ready", 32'(bus8.req_ready), 32'b0010);
    step();
    chk("postrst_rsp_id",    32'(bus8.rsp_id),    32'd1);
    chk("postrst_rsp_valid", 32'(bus8.rsp_valid), 32'd1);
    bus8.req_valid = 4'b1000;
    #1;
    chk("postrst_next_ready", 32'(bus8.req_ready), 32'b1000);
    step();
    chk("postrst_next_id", 32'(bus8.rsp_id), 32'd3);
    bus8.req_valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
